// File: rtl/jesd204_rx_lane_align_if.sv
// Bus bundle for the JESD204B receive lane aligner: raw 8B/10B-decoded lane
// inputs on one side, deskewed multi-lane data and link status on the other.
// rx_valid has no back-pressure: each aligned beat is presented on rx_data for
// exactly one cycle while rx_valid is high, and the consumer must take it.
interface jesd204_rx_lane_align_if #(
    parameter int NUM_LANES    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 16
);
    logic [NUM_LANES*DATA_WIDTH-1:0]   jesd_data;
    logic [NUM_LANES*4-1:0]            jesd_charisk;
    logic [NUM_LANES*4-1:0]            jesd_notintable;
    logic [NUM_LANES*4-1:0]            jesd_disperr;
    logic [NUM_LANES*DATA_WIDTH-1:0]   rx_data;
    logic                              rx_valid;
    logic                              link_ready;
    logic                              jesd_sync_n;
    logic                              align_error;
    logic [2*NUM_LANES-1:0]            lane_cgs_state;
    logic [$clog2(BUFFER_DEPTH)-1:0]   skew_beats;

    // Lane-interface side: supplies decoded lane beats, observes link status.
    modport master (
        output jesd_data, jesd_charisk, jesd_notintable, jesd_disperr,
        input  rx_data, rx_valid, link_ready, jesd_sync_n, align_error,
               lane_cgs_state, skew_beats
    );

    // Aligner side.
    modport slave (
        input  jesd_data, jesd_charisk, jesd_notintable, jesd_disperr,
        output rx_data, rx_valid, link_ready, jesd_sync_n, align_error,
               lane_cgs_state, skew_beats
    );
endinterface

// File: rtl/jesd204_rx_lane_align.sv
// JESD204B receive link layer: per-lane code-group sync, ILAS start detection
// and multi-lane deskew through per-lane elastic buffers read in lockstep.
module jesd204_rx_lane_align #(
    parameter int NUM_LANES    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 16,
    parameter int CGS_K_COUNT  = 4
) (
    input  logic                   jesd_clk,
    input  logic                   reset,
    jesd204_rx_lane_align_if.slave bus
);
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int KW = $clog2(CGS_K_COUNT + 1);

    localparam logic [1:0] CS_INIT = 2'd0;
    localparam logic [1:0] CS_DATA = 2'd1;
    localparam logic [1:0] CS_RUN  = 2'd2;

    localparam logic [KW-1:0] K_LAST = KW'(CGS_K_COUNT - 1);
    // Skew counter value one below the limit; the increment from here is fatal.
    localparam logic [AW-1:0] SKEW_LAST = AW'(BUFFER_DEPTH - 2);

    logic [1:0]            state     [NUM_LANES];
    logic [1:0]            state_nxt [NUM_LANES];
    logic [KW-1:0]         k_cnt     [NUM_LANES];
    logic [KW-1:0]         k_cnt_nxt [NUM_LANES];
    logic [1:0]            err_cnt     [NUM_LANES];
    logic [1:0]            err_cnt_nxt [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_err, lane_all_k, lane_r, lane_drop, wr_en;

    logic [DATA_WIDTH-1:0] mem [NUM_LANES][BUFFER_DEPTH];
    logic [AW-1:0]         wr_ptr [NUM_LANES];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         skew_cnt;
    logic [AW-1:0]         skew_q;
    logic                  released;
    logic                  any_run, all_run, timeout, drop, release_now, rd_en;

    logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q, link_ready_q, align_error_q;

    // Character and error decode for each lane's current beat.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_err[i]   = (|bus.jesd_notintable[i*4 +: 4]) | (|bus.jesd_disperr[i*4 +: 4]);
            lane_all_k[i] = 1'b1;
            for (int o = 0; o < 4; o++) begin
                lane_all_k[i] = lane_all_k[i] & bus.jesd_charisk[i*4 + o]
                              & (bus.jesd_data[i*DATA_WIDTH + o*8 +: 8] == 8'hBC);
            end
            lane_r[i] = bus.jesd_charisk[i*4] & (bus.jesd_data[i*DATA_WIDTH +: 8] == 8'h1C);
        end
    end

    // Per-lane CGS state machine and consecutive-error tracking.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            state_nxt[i]   = state[i];
            k_cnt_nxt[i]   = k_cnt[i];
            err_cnt_nxt[i] = err_cnt[i];
            lane_drop[i]   = 1'b0;
            case (state[i])
                CS_INIT: begin
                    // Errors here only break the /K/ run.
                    if (lane_all_k[i] && !lane_err[i]) begin
                        if (k_cnt[i] == K_LAST) begin
                            state_nxt[i]   = CS_DATA;
                            k_cnt_nxt[i]   = '0;
                            err_cnt_nxt[i] = '0;
                        end else begin
                            k_cnt_nxt[i] = k_cnt[i] + 1'b1;
                        end
                    end else begin
                        k_cnt_nxt[i] = '0;
                    end
                end
                CS_DATA, CS_RUN: begin
                    if (lane_err[i]) begin
                        if (err_cnt[i] == 2'd2) lane_drop[i] = 1'b1;
                        else                    err_cnt_nxt[i] = err_cnt[i] + 1'b1;
                    end else begin
                        err_cnt_nxt[i] = '0;
                        if (state[i] == CS_DATA && lane_r[i]) state_nxt[i] = CS_RUN;
                    end
                end
                default: state_nxt[i] = CS_INIT;
            endcase
        end
    end

    // Link-level decisions: skew timeout, drop, release and buffer strobes.
    always_comb begin
        any_run = 1'b0;
        all_run = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            any_run  = any_run | (state_nxt[i] == CS_RUN);
            all_run  = all_run & (state_nxt[i] == CS_RUN);
            wr_en[i] = (state_nxt[i] == CS_RUN);
        end
        // A lane arriving on the limit edge completes alignment instead.
        timeout     = !released && any_run && !all_run && (skew_cnt == SKEW_LAST);
        drop        = (|lane_drop) || timeout;
        release_now = !released && all_run && !drop;
        rd_en       = released && !drop;
    end

    // Lane FSM registers; a link drop returns every lane to CS_INIT.
    always_ff @(posedge jesd_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state[i]   <= CS_INIT;
                k_cnt[i]   <= '0;
                err_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state[i]   <= drop ? CS_INIT : state_nxt[i];
                k_cnt[i]   <= drop ? '0 : k_cnt_nxt[i];
                err_cnt[i] <= drop ? '0 : err_cnt_nxt[i];
            end
        end
    end

    // Deskew buffer storage; validity is tracked purely by the pointers.
    always_ff @(posedge jesd_clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i]] <= bus.jesd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pointers, skew measurement, release and registered outputs.
    always_ff @(posedge jesd_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) wr_ptr[i] <= '0;
            rd_ptr        <= '0;
            skew_cnt      <= '0;
            skew_q        <= '0;
            released      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            link_ready_q  <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            align_error_q <= timeout;
            if (drop) begin
                for (int i = 0; i < NUM_LANES; i++) wr_ptr[i] <= '0;
                rd_ptr       <= '0;
                skew_cnt     <= '0;
                released     <= 1'b0;
                rx_valid_q   <= 1'b0;
                link_ready_q <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (release_now) begin
                    released <= 1'b1;
                    skew_q   <= skew_cnt;
                end
                // Counts cycles since the first lane started, until release.
                if (released || release_now || !any_run) skew_cnt <= '0;
                else                                     skew_cnt <= skew_cnt + 1'b1;
                rx_valid_q   <= rd_en;
                link_ready_q <= rd_en;
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        rx_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[i][rd_ptr];
                    end
                end
            end
        end
    end

    // SYNC~ and per-lane state follow the FSM registers directly.
    always_comb begin
        bus.jesd_sync_n = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.lane_cgs_state[i*2 +: 2] = state[i];
            if (state[i] == CS_INIT) bus.jesd_sync_n = 1'b0;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.link_ready  = link_ready_q;
    assign bus.align_error = align_error_q;
    assign bus.skew_beats  = skew_q;
endmodule
